// File: rtl/inst_fetch.sv
// Instruction fetch stage: loadable program memory, start/stop fetch PC with wrap and redirect,
// and a 2-entry output FIFO feeding decode over a valid/ready handshake.
module inst_fetch #(
  parameter int unsigned IW = 14,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          run,
  input  logic [AW-1:0] start_pc,
  input  logic [AW-1:0] last_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] inst_out,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          done
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] stop_pc_q, stop_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic [IW-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0] fifo_inst_q [2];
  logic [IW-1:0] fifo_inst_d [2];
  logic [AW-1:0] fifo_pc_q [2];
  logic [AW-1:0] fifo_pc_d [2];
  logic [1:0]    count_q, count_d;
  logic          done_q, done_d;

  logic [IW-1:0] mem_q [Depth];

  logic          pop;
  logic          issue;
  logic          flush;
  logic          room;
  logic [2:0]    occupancy;
  logic [1:0]    cnt;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign inst_out  = out_valid ? fifo_inst_q[0] : '0;
  assign pc_out    = out_valid ? fifo_pc_q[0] : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // Slots committed after this edge: entries that stay plus the read about to land.
  assign occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign room      = (occupancy < 3'd2);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stop_pc_d  = stop_pc_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StRun;
          fetch_pc_d = start_pc;
          stop_pc_d  = last_pc;
        end
      end
      StRun: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (room) begin
          issue      = 1'b1;
          fetch_pc_d = fetch_pc_q + AW'(1);
          if (fetch_pc_q == stop_pc_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = StRun;
        end else if ((count_q == 2'd0) && !inflight_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data_d     = rd_data_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    fifo_inst_d   = fifo_inst_q;
    fifo_pc_d     = fifo_pc_q;
    cnt           = count_q;
    if (issue) begin
      rd_data_d     = mem_q[fetch_pc_q];
      inflight_pc_d = fetch_pc_q;
    end
    if (flush) begin
      cnt        = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (pop) begin
        fifo_inst_d[0] = fifo_inst_q[1];
        fifo_pc_d[0]   = fifo_pc_q[1];
        cnt            = cnt - 2'd1;
      end
      if (inflight_q) begin
        fifo_inst_d[cnt[0]] = rd_data_q;
        fifo_pc_d[cnt[0]]   = inflight_pc_q;
        cnt                 = cnt + 2'd1;
      end
    end
    count_d = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      fetch_pc_q     <= '0;
      stop_pc_q      <= '0;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      rd_data_q      <= '0;
      fifo_inst_q[0] <= '0;
      fifo_inst_q[1] <= '0;
      fifo_pc_q[0]   <= '0;
      fifo_pc_q[1]   <= '0;
      count_q        <= 2'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      stop_pc_q      <= stop_pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      rd_data_q      <= rd_data_d;
      fifo_inst_q[0] <= fifo_inst_d[0];
      fifo_inst_q[1] <= fifo_inst_d[1];
      fifo_pc_q[0]   <= fifo_pc_d[0];
      fifo_pc_q[1]   <= fifo_pc_d[1];
      count_q        <= count_d;
      done_q         <= done_d;
    end
  end

  // Program memory is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && load_en) mem_q[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: program-level scoreboard of expected PCs plus literal timing pins.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [13:0] load_data = '0;
  logic        run = 1'b0;
  logic [4:0]  start_pc = '0;
  logic [4:0]  last_pc = '0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] inst_out;
  logic [4:0]  pc_out;
  logic        busy;
  logic        done;

  inst_fetch #(.IW(14), .AW(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .run(run), .start_pc(start_pc), .last_pc(last_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .pc_out(pc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_xfer = 0;
  int          exp_q[$];
  logic [13:0] model_mem [32];
  bit          held_v = 1'b0;
  logic [4:0]  held_pc;
  logic [13:0] held_inst;
  bit          toggle_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected fetch order from s through l, wrapping 31 -> 0.
  task automatic build(input int s, input int l);
    int p;
    p = s;
    forever begin
      exp_q.push_back(p);
      if (p == l) break;
      p = (p + 1) % 32;
    end
  endtask

  task automatic load(input int a, input logic [13:0] d);
    load_en = 1'b1; load_addr = 5'(a); load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_run(input int s, input int l);
    n_xfer = 0;
    build(s, l);
    run = 1'b1; start_pc = 5'(s); last_pc = 5'(l);
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (toggle_ready) out_ready = ((k % 3) == 0);
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    chk({name, "_done"}, 32'(seen), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (held_v) begin
          chk("hold_pc", 32'(pc_out), 32'(held_pc));
          chk("hold_inst", 32'(inst_out), 32'(held_inst));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got pc %0d expected no transfer", pc_out);
          end else begin
            int e;
            e = exp_q.pop_front();
            chk("xfer_pc", 32'(pc_out), 32'(e));
            chk("xfer_inst", 32'(inst_out), 32'(model_mem[e]));
            n_xfer++;
          end
        end
      end
      held_v    = out_valid && !out_ready;
      held_pc   = pc_out;
      held_inst = inst_out;
    end
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inst", 32'(inst_out), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);

    // Test 1: straight run 0..3 at full rate.
    for (int i = 0; i < 4; i++) load(i, 14'(i + 1));
    start_run(0, 3);
    chk("t1_c0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_c1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_seq_valid", 32'(out_valid), 32'd1);
      chk("t1_seq_pc", 32'(pc_out), 32'(i));
      chk("t1_seq_inst", 32'(inst_out), 32'(i + 1));
    end
    chk("t1_busy_last", 32'(busy), 32'd1);
    tick();
    chk("t1_c6_done", 32'(done), 32'd0);
    chk("t1_c6_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_c7_done", 32'(done), 32'd1);
    chk("t1_c7_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_c8_done", 32'(done), 32'd0);
    chk("t1_count", 32'(n_xfer), 32'd4);

    // Test 2: same program under back-pressure.
    toggle_ready = 1'b1;
    start_run(0, 3);
    wait_done("t2", 60);
    toggle_ready = 1'b0;
    chk("t2_count", 32'(n_xfer), 32'd4);

    // Test 3: wrap 30 -> 1.
    load(30, 14'h3A); load(31, 14'h3B); load(0, 14'h0C); load(1, 14'h0D);
    start_run(30, 1);
    tick();
    tick();
    chk("t3_first_pc", 32'(pc_out), 32'd30);
    chk("t3_first_inst", 32'(inst_out), 32'h3A);
    tick();
    tick();
    chk("t3_third_pc", 32'(pc_out), 32'd0);
    chk("t3_third_inst", 32'(inst_out), 32'h0C);
    wait_done("t3", 20);
    chk("t3_count", 32'(n_xfer), 32'd4);

    // Test 4: redirect to 20 on the cycle of the second transfer.
    for (int i = 0; i < 32; i++) load(i, 14'(14'h1000 + i * 5));
    start_run(0, 7);
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 5'd20;
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    build(20, 7);
    chk("t4_r0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t4_r1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t4_r2_valid", 32'(out_valid), 32'd1);
    chk("t4_r2_pc", 32'(pc_out), 32'd20);
    chk("t4_r2_inst", 32'(inst_out), 32'h1064);
    wait_done("t4", 80);
    chk("t4_count", 32'(n_xfer), 32'd22);

    // Test 5: load during RUN is ignored; rst mid-run drops everything but keeps memory.
    start_run(0, 7);
    load_en = 1'b1; load_addr = 5'd5; load_data = 14'h3FFF;
    tick();
    load_en = 1'b0;
    wait_done("t5a", 40);
    chk("t5a_count", 32'(n_xfer), 32'd8);
    start_run(0, 7);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_pc", 32'(pc_out), 32'd0);
    tick();
    start_run(5, 5);
    tick();
    tick();
    chk("t5b_pc", 32'(pc_out), 32'd5);
    chk("t5b_inst", 32'(inst_out), 32'h1019);
    wait_done("t5b", 20);
    chk("t5b_count", 32'(n_xfer), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the 5-stage core pipeline. Holds a 32 x 14-bit loadable program memory, runs its own fetch PC from a start address to a stop address (with wrap-around and redirect), and delivers one instruction plus its PC per cycle to decode over a valid/ready handshake. A 2-entry output FIFO absorbs decode back-pressure without losing in-flight reads.

## Interface
- IW, 14, instruction width (matches decoder input)
- AW, 5, PC/address width; memory depth = 2^AW
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- load_en  in  1  program-memory write strobe; honoured only in IDLE
- load_addr  in  AW  write address
- load_data  in  IW  write data
- run  in  1  start fetching; sampled only in IDLE
- start_pc  in  AW  first fetch address, sampled with run
- last_pc  in  AW  final address to fetch, sampled with run
- redirect_valid  in  1  flush and restart fetch at redirect_pc (RUN/DRAIN only)
- redirect_pc  in  AW  new fetch address
- out_valid  out  1  inst_out/pc_out hold a valid instruction
- out_ready  in  1  decode accepts; transfer when out_valid & out_ready
- inst_out  out  IW  instruction at FIFO head
- pc_out  out  AW  address of inst_out
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN -> IDLE

## Operation
- Reset: state IDLE, fetch_pc 0, FIFO empty, inflight 0; out_valid 0, inst_out 0, pc_out 0, busy 0, done 0. Memory contents are not reset.
- Memory: synchronous write; synchronous read, 1-cycle latency; read data + its address captured in flight register.
- States: IDLE, RUN, DRAIN.
  - IDLE: load_en writes mem[load_addr]. run=1 -> RUN, fetch_pc <= start_pc, stop latch <= last_pc. run and load_en in same cycle: load performed, run taken.
  - RUN: issue read of fetch_pc when (count - pop) + inflight < 2; pop = out_valid & out_ready. Each issue: fetch_pc <= fetch_pc + 1 mod 2^AW (31 -> 0). Issue of address == stop latch -> DRAIN.
  - DRAIN: no issue; when FIFO empty and inflight 0 -> IDLE, done=1 that cycle's edge for one cycle.
- Returned read data pushed into FIFO at the edge after issue; FIFO never overflows by the issue rule.
- Redirect (RUN or DRAIN): FIFO cleared, in-flight read discarded, fetch_pc <= redirect_pc, state -> RUN; a simultaneous pop is treated as accepted; no issue in the redirect cycle. Ignored in IDLE.
- load_en outside IDLE: ignored, memory unchanged.
- start_pc == last_pc: exactly one instruction fetched.
- last_pc < start_pc: fetch wraps through 31 -> 0 up to last_pc.
- rst mid-operation: returns to reset state next edge, all queued/in-flight instructions dropped.

## Timing
- run sampled at edge E0 -> first read issued cycle after E0 -> out_valid=1 after edge E2 (2-cycle start latency).
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- out_ready=0: at most 2 instructions buffered, issue stalls; resume at full rate the cycle out_ready returns.
- inst_out/pc_out stable while out_valid & !out_ready.
- Redirect at edge R: out_valid=0 after R; first redirected instruction valid after R+2.
- done asserted for exactly one cycle; busy drops the same edge.
- load_en at edge L visible to a read issued after L.

## Test plan
- Load mem[0..3] = 14'h0001..14'h0004, run with start_pc 0, last_pc 3, out_ready=1 -> 4 transfers, pc_out 0,1,2,3 on consecutive cycles, first 2 cycles after run, done pulse after last.
- Same program, out_ready toggles 1,0,0,1,... -> sequence 0001..0004 in order, no duplicates/loss, outputs stable during stalls.
- start_pc 30, last_pc 1, mem[30,31,0,1] = 14'h3A,14'h3B,14'h0C,14'h0D -> pc_out 30,31,0,1 with matching data.
- Run 0..7, redirect_valid with redirect_pc 20 after 2 transfers (pop in same cycle) -> next valid output pc 20 after 2 cycles, no pc 2/3 delivered, continues 21.. until last_pc 7 via wrap.
- load_en during RUN to mem[5]=14'h3FFF -> mem[5] unchanged on later fetch; rst asserted mid-RUN -> out_valid 0, busy 0 next cycle, memory retained for next run.
